operand2_fetch: RTL and testbench
=================================

Name: operand2_fetch

Overview:
- Upstream neighbour of the barrel shifter in the ARM32 execute path.
- Accepts one data-processing instruction from decode and reads Rn, Rm and Rs through the single register-file read port.
- Decodes the ARM operand2 field (rotated immediate, immediate-shifted register, register-shifted register).
- Presents operand A plus shifter inputs (shift_in, shift_op, shift_amt) to the shifter/ALU stage under a valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 4, register index width (16 architectural registers).

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort of the in-flight instruction
- in_valid  input  1  decode offers an instruction
- in_ready  output  1  block can accept; high only in IDLE and not in reset
- in_instr  input  32  ARM data-processing instruction word
- rf_rd_en  output  1  register-file read request
- rf_rd_addr  output  REG_AW  register index to read
- rf_rd_data  input  DATA_W  read data, valid the cycle after rf_rd_en
- out_valid  output  1  operands valid
- out_ready  input  1  shifter/ALU stage accepts
- op_a  output  DATA_W  Rn value
- shift_in  output  DATA_W  value to shift
- shift_op  output  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- shift_amt  output  32  shift amount, zero-extended
- rrx  output  1  ROR #0 immediate form (RRX); downstream inserts carry

Behaviour:
- Fields:
  - I = instr[25]; Rn = [19:16]; Rm = [3:0]; Rs = [11:8]; type = [6:5]; reg-shift = instr[4] when I=0.
- Decode:
  - I=1: shift_in = zero-extended instr[7:0]; shift_op = 11; shift_amt = instr[11:8]*2; no Rm/Rs read.
  - I=0, instr[4]=0: shift_in = Rm; shift_op = type; shift_amt = instr[11:7].
    - LSR/ASR with amount 0 gives shift_amt = 32.
    - ROR with amount 0 gives shift_amt = 1 and rrx = 1.
    - LSL #0 stays 0.
  - I=0, instr[4]=1: shift_in = Rm; shift_op = type; shift_amt = {24'b0, Rs[7:0]}; rrx = 0.
- FSM states: IDLE, RN, RM, RS, CAP, OUT.
  - IDLE: in_ready = 1. On in_valid, latch instr and go to RN.
  - RN: rf_rd_en = 1, addr = Rn. Go to CAP if I=1, else RM.
  - RM: capture rf_rd_data into op_a; read Rm. Go to RS if reg-shift, else CAP.
  - RS: capture Rm into shift_in; read Rs. Go to CAP.
  - CAP: capture the previous read (op_a, Rm or Rs); compute shift fields. Go to OUT.
  - OUT: out_valid = 1. Go to IDLE when out_ready = 1, else hold.
- Latency from the accept cycle to out_valid: immediate 3 cycles; imm-shifted register 4; register-shifted register 5.
- No overlap: the next instruction is accepted no earlier than the cycle after the OUT handshake. Throughput is one instruction per 4/5/6 cycles.
- Backpressure: all outputs stay stable while out_valid = 1 and out_ready = 0.
- rf_rd_en = 0 and rf_rd_addr = 0 in IDLE, CAP and OUT.
- Register 15 reads return whatever the register file supplies; no PC adjustment here.
- flush:
  - Any state returns to IDLE next cycle; out_valid drops next cycle.
  - flush beats out_ready in OUT; the flushed transfer counts as not delivered.
  - flush in IDLE together with in_valid: instruction is not accepted.
- rst: state = IDLE. out_valid, rf_rd_en, op_a, shift_in, shift_op, shift_amt, rrx and rf_rd_addr all 0. in_ready = 0 while rst is high. Reset mid-operation discards the instruction.

Decomposition:
- Shared package arm_pkg:
  - shift_op_t enum (LSL=00, LSR=01, ASR=10, ROR=11).
  - op2_state_t enum.
  - Field position constants (I_BIT=25, RN_LSB=16, RS_LSB=8, SHTYPE_LSB=5, REGSHIFT_BIT=4).
- Sub-module op2_field_decode: combinational decode of the latched instruction into form (imm / imm-shift / reg-shift), register indices, immediate shift_op/shift_amt, and the rrx flag.

Test Plan:
- Rotated immediate: instr 0xE3A014FF (I=1, rot=4, imm=0xFF), Rn data 0x5, out_ready=1 -> out_valid 3 cycles after accept; shift_in=0xFF, shift_op=11, shift_amt=8, op_a=0x5.
- LSR #0: instr 0xE1A00021 (Rm=r1=0x80000000) -> shift_op=01, shift_amt=32, rrx=0, 4-cycle latency.
- RRX: instr 0xE1A00061 -> shift_op=11, shift_amt=1, rrx=1.
- Register shift: instr 0xE1A00312 (LSL r2 by r3), r2=0x1, r3=0x00000104 -> shift_in=0x1, shift_amt=4 (Rs[7:0]); read order Rn, r2, r3; 5-cycle latency.
- Backpressure and flush:
  - Hold out_ready=0 for 6 cycles -> outputs constant, in_ready=0.
  - Then assert flush -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-RS: assert rst -> all outputs 0 next cycle; a new instruction accepted after release completes normally.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM32 execute-path types and instruction field positions.
package arm_pkg;

   // Barrel-shifter operation encoding, identical to the instruction's type field.
   typedef enum logic [1:0] {
      LSL = 2'b00,
      LSR = 2'b01,
      ASR = 2'b10,
      ROR = 2'b11
   } shift_op_t;

   // Operand-2 fetch sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RN,
      ST_RM,
      ST_RS,
      ST_CAP,
      ST_OUT
   } op2_state_t;

   // The three data-processing operand-2 forms.
   typedef enum logic [1:0] {
      FORM_IMM,
      FORM_IMM_SHIFT,
      FORM_REG_SHIFT
   } op2_form_t;

   // Bit positions within the data-processing instruction word.
   localparam int I_BIT        = 25;
   localparam int RN_LSB       = 16;
   localparam int RS_LSB       = 8;
   localparam int ROT_LSB      = 8;
   localparam int SHAMT_LSB    = 7;
   localparam int SHTYPE_LSB   = 5;
   localparam int REGSHIFT_BIT = 4;
   localparam int RM_LSB       = 0;
   localparam int IMM8_LSB     = 0;

endpackage

// File: rtl/op2_field_decode.sv
// Combinational decode of a latched data-processing instruction into its
// operand-2 form, register indices and immediate shift controls.
module op2_field_decode
   import arm_pkg::*;
(
   input  logic [31:0] instr_i,
   output op2_form_t   form_o,
   output logic [3:0]  rn_idx_o,
   output logic [3:0]  rm_idx_o,
   output logic [3:0]  rs_idx_o,
   output logic [7:0]  imm8_o,
   output shift_op_t   shift_op_o,
   output logic [31:0] shift_amt_o,
   output logic        rrx_o
);

   logic [4:0] shamt5;
   shift_op_t  sh_type;
   logic       unused_bits;

   assign rn_idx_o = instr_i[RN_LSB +: 4];
   assign rm_idx_o = instr_i[RM_LSB +: 4];
   assign rs_idx_o = instr_i[RS_LSB +: 4];
   assign imm8_o   = instr_i[IMM8_LSB +: 8];
   assign shamt5   = instr_i[SHAMT_LSB +: 5];
   assign sh_type  = shift_op_t'(instr_i[SHTYPE_LSB +: 2]);

   // Condition, opcode, S and Rd fields do not affect operand 2.
   assign unused_bits = ^{instr_i[31:26], instr_i[24:20], instr_i[15:12]};

   // Classify the form and map the immediate shift encodings, including the
   // zero-amount special cases (LSR/ASR #32, RRX).
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
      form_o      = FORM_IMM_SHIFT;
      shift_op_o  = sh_type;
      shift_amt_o = '0;
      rrx_o       = 1'b0;
      if (instr_i[I_BIT]) begin
         form_o      = FORM_IMM;
         shift_op_o  = ROR;
         shift_amt_o = {27'b0, instr_i[ROT_LSB +: 4], 1'b0};
      end else if (instr_i[REGSHIFT_BIT]) begin
         form_o = FORM_REG_SHIFT;
      end else if (shamt5 == 5'd0) begin
         case (sh_type)
            LSR, ASR: shift_amt_o = 32'd32;
            ROR: begin
               shift_amt_o = 32'd1;
               rrx_o       = 1'b1;
            end
            default:  shift_amt_o = 32'd0;
         endcase
      end else begin
         shift_amt_o = {27'b0, shamt5};
      end
   end

endmodule

// File: rtl/operand2_fetch.sv
// Operand-2 fetch: sequences Rn/Rm/Rs reads through a single register-file
// port and presents operand A plus shifter controls to the shifter stage.
module operand2_fetch
   import arm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   output logic              rf_rd_en,
   output logic [REG_AW-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] shift_in,
   output logic [1:0]        shift_op,
   output logic [31:0]       shift_amt,
   output logic              rrx
);

   op2_state_t        state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] shift_in_q, shift_in_d;
   shift_op_t         shift_op_q, shift_op_d;
   logic [31:0]       shift_amt_q, shift_amt_d;
   logic              rrx_q, rrx_d;

   op2_form_t   dec_form;
   logic [3:0]  dec_rn, dec_rm, dec_rs;
   logic [7:0]  dec_imm8;
   shift_op_t   dec_shift_op;
   logic [31:0] dec_shift_amt;
   logic        dec_rrx;

   op2_field_decode u_decode (
      .instr_i     (instr_q),
      .form_o      (dec_form),
      .rn_idx_o    (dec_rn),
      .rm_idx_o    (dec_rm),
      .rs_idx_o    (dec_rs),
      .imm8_o      (dec_imm8),
      .shift_op_o  (dec_shift_op),
      .shift_amt_o (dec_shift_amt),
      .rrx_o       (dec_rrx)
   );

   // Read sequencing and next-state/datapath selection; each read lands one
   // cycle later and is captured by the following state.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      op_a_d      = op_a_q;
      shift_in_d  = shift_in_q;
      shift_op_d  = shift_op_q;
      shift_amt_d = shift_amt_q;
      rrx_d       = rrx_q;
      rf_rd_en    = 1'b0;
      rf_rd_addr  = '0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = !rst;
            if (in_valid && !flush) begin
               instr_d = in_instr;
               state_d = ST_RN;
            end
         end
         ST_RN: begin
            rf_rd_en   = 1'b1;
            rf_rd_addr = REG_AW'(dec_rn);
            state_d    = (dec_form == FORM_IMM) ? ST_CAP : ST_RM;
         end
         ST_RM: begin
            op_a_d     = rf_rd_data;
            rf_rd_en   = 1'b1;
            rf_rd_addr = REG_AW'(dec_rm);
            state_d    = (dec_form == FORM_REG_SHIFT) ? ST_RS : ST_CAP;
         end
         ST_RS: begin
            shift_in_d = rf_rd_data;
            rf_rd_en   = 1'b1;
            rf_rd_addr = REG_AW'(dec_rs);
            state_d    = ST_CAP;
         end
         ST_CAP: begin
            shift_op_d = dec_shift_op;
            case (dec_form)
               FORM_IMM: begin
                  op_a_d      = rf_rd_data;
                  shift_in_d  = {{(DATA_W-8){1'b0}}, dec_imm8};
                  shift_amt_d = dec_shift_amt;
                  rrx_d       = 1'b0;
               end
               FORM_IMM_SHIFT: begin
                  shift_in_d  = rf_rd_data;
                  shift_amt_d = dec_shift_amt;
                  rrx_d       = dec_rrx;
               end
               default: begin
                  shift_amt_d = {24'b0, rf_rd_data[7:0]};
                  rrx_d       = 1'b0;
               end
            endcase
            state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over every other transition, including the output handshake.
      if (flush) state_d = ST_IDLE;
   end

   // State and output registers with synchronous reset to an empty, idle block.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_IDLE;
         instr_q     <= '0;
         op_a_q      <= '0;
         shift_in_q  <= '0;
         shift_op_q  <= LSL;
         shift_amt_q <= '0;
         rrx_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         op_a_q      <= op_a_d;
         shift_in_q  <= shift_in_d;
         shift_op_q  <= shift_op_d;
         shift_amt_q <= shift_amt_d;
         rrx_q       <= rrx_d;
      end
   end

   assign op_a      = op_a_q;
   assign shift_in  = shift_in_q;
   assign shift_op  = shift_op_q;
   assign shift_amt = shift_amt_q;
   assign rrx       = rrx_q;

endmodule

// File: tb/tb_operand2_fetch.sv
// Scoreboard bench for operand2_fetch: directed instructions with
// hand-computed operands, read order and latency.
module tb_operand2_fetch;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_ready, out_valid;
   logic [31:0] in_instr;
   logic        rf_rd_en;
   logic [3:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic [31:0] op_a, shift_in, shift_amt;
   logic [1:0]  shift_op;
   logic        rrx;

   always #5 clk = ~clk;

   operand2_fetch #(.DATA_W(32), .REG_AW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rf_rd_en   (rf_rd_en),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .op_a       (op_a),
      .shift_in   (shift_in),
      .shift_op   (shift_op),
      .shift_amt  (shift_amt),
      .rrx        (rrx)
   );

   // Register-file model: one-cycle read latency.
   logic [31:0] rf [16];
   always @(posedge clk) rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : 32'h0;

   typedef struct {
      logic [31:0] op_a;
      logic [31:0] shift_in;
      logic [1:0]  op;
      logic [31:0] amt;
      logic        rrx;
      int          lat;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] rd_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int n_done   = 0;
   int acc_cyc  = 0;
   bit acc_pend = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] s,
                               input logic [1:0] op, input logic [31:0] amt,
                               input logic r, input int lat);
      exp_t e;
      e.op_a = a; e.shift_in = s; e.op = op; e.amt = amt; e.rrx = r; e.lat = lat;
      return e;
   endfunction

   // Monitor: checks read order, accept-to-valid latency and delivered operands.
   always @(negedge clk) begin
      if (rst) begin
         acc_pend = 1'b0;
      end else begin
         if (rf_rd_en) begin
            if (rd_q.size() == 0) check("unexpected_read", 32'(rf_rd_addr), 32'hFFFF_FFFF);
            else                  check("rf_rd_addr", 32'(rf_rd_addr), 32'(rd_q.pop_front()));
         end
         if (in_valid && in_ready && !flush) begin
            acc_pend = 1'b1;
            acc_cyc  = cyc;
         end
         if (out_valid && acc_pend) begin
            acc_pend = 1'b0;
            if (exp_q.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'h0);
            else                   check("latency", 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
         end
         if (out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(out_valid), 32'h0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("op_a", op_a, e.op_a);
               check("shift_in", shift_in, e.shift_in);
               check("shift_op", 32'(shift_op), 32'(e.op));
               check("shift_amt", shift_amt, e.amt);
               check("rrx", 32'(rrx), 32'(e.rrx));
            end
            done_cnt++;
         end
      end
   end

   // Offer one instruction; returns just after the accepting edge.
   task automatic send(input logic [31:0] instr, input exp_t e,
                       input logic [11:0] rds, input int nrd);
      int k;
      exp_q.push_back(e);
      for (int i = 0; i < nrd; i++) rd_q.push_back(rds[i*4 +: 4]);
      in_instr = instr;
      in_valid = 1'b1;
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (in_ready) break;
         k++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      n_done++;
      k = 0;
      while (done_cnt < n_done && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      check("delivered", 32'(done_cnt), 32'(n_done));
   endtask

   task automatic wait_out_valid();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 20);
      check("out_valid_seen", 32'(out_valid), 32'h1);
   endtask

   task automatic run(input logic [31:0] instr, input exp_t e,
                      input logic [11:0] rds, input int nrd);
      send(instr, e, rds, nrd);
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      rf[0] = 32'h0000_0005;  rf[1] = 32'h8000_0000;
      rf[2] = 32'h0000_0001;  rf[3] = 32'h0000_0104;
      rf[4] = 32'hDEAD_BEEF;  rf[5] = 32'hFFFF_FF21;
      rf[6] = 32'h8000_0001;  rf[7] = 32'h1234_5678;
      rf[15] = 32'hCAFE_F00D;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_rf_rd_en", 32'(rf_rd_en), 32'h0);
      check("rst_rf_rd_addr", 32'(rf_rd_addr), 32'h0);
      check("rst_op_a", op_a, 32'h0);
      check("rst_shift_in", shift_in, 32'h0);
      check("rst_shift_op", 32'(shift_op), 32'h0);
      check("rst_shift_amt", shift_amt, 32'h0);
      check("rst_rrx", 32'(rrx), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;

      // Directed vectors: instr, expected (op_a, shift_in, op, amt, rrx, latency), reads.
      run(32'hE3A014FF, mk(32'h5, 32'hFF, 2'b11, 32'd8, 1'b0, 3), 12'h000, 1);
      run(32'hE1A00021, mk(32'h5, 32'h8000_0000, 2'b01, 32'd32, 1'b0, 4), 12'h010, 2);
      run(32'hE1A00061, mk(32'h5, 32'h8000_0000, 2'b11, 32'd1, 1'b1, 4), 12'h010, 2);
      run(32'hE1A00312, mk(32'h5, 32'h1, 2'b00, 32'd4, 1'b0, 5), 12'h320, 3);
      run(32'hE1A00002, mk(32'h5, 32'h1, 2'b00, 32'd0, 1'b0, 4), 12'h020, 2);
      run(32'hE1A00041, mk(32'h5, 32'h8000_0000, 2'b10, 32'd32, 1'b0, 4), 12'h010, 2);
      run(32'hE1A002A1, mk(32'h5, 32'h8000_0000, 2'b01, 32'd5, 1'b0, 4), 12'h010, 2);
      run(32'hE0841FE3, mk(32'hDEAD_BEEF, 32'h104, 2'b11, 32'd31, 1'b0, 4), 12'h034, 2);
      run(32'hE0870556, mk(32'h1234_5678, 32'h8000_0001, 2'b10, 32'd33, 1'b0, 5), 12'h567, 3);
      run(32'hE28F007F, mk(32'hCAFE_F00D, 32'h7F, 2'b11, 32'd0, 1'b0, 3), 12'h00F, 1);
      run(32'hE3A00F01, mk(32'h5, 32'h1, 2'b11, 32'd30, 1'b0, 3), 12'h000, 1);

      // Backpressure: outputs hold their expected values, no new accept.
      out_ready = 1'b0;
      send(32'hE1A00312, mk(32'h5, 32'h1, 2'b00, 32'd4, 1'b0, 5), 12'h320, 3);
      wait_out_valid();
      for (int i = 0; i < 6; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'h1);
         check("bp_in_ready", 32'(in_ready), 32'h0);
         check("bp_op_a", op_a, 32'h5);
         check("bp_shift_in", shift_in, 32'h1);
         check("bp_shift_op", 32'(shift_op), 32'h0);
         check("bp_shift_amt", shift_amt, 32'd4);
         check("bp_rrx", 32'(rrx), 32'h0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'h0);
      check("flush_in_ready", 32'(in_ready), 32'h1);
      void'(exp_q.pop_front());
      @(posedge clk); #1;

      // Flush together with out_ready: transfer is not delivered.
      out_ready = 1'b0;
      send(32'hE1A00021, mk(32'h5, 32'h8000_0000, 2'b01, 32'd32, 1'b0, 4), 12'h010, 2);
      wait_out_valid();
      @(posedge clk); #1;
      out_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_wins_out_valid", 32'(out_valid), 32'h0);
      check("flush_wins_not_delivered", 32'(done_cnt), 32'(n_done));
      void'(exp_q.pop_front());
      @(posedge clk); #1;

      // Flush in IDLE with in_valid: instruction is not accepted.
      in_instr = 32'hE3A014FF;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("idle_flush_in_ready", 32'(in_ready), 32'h1);
      check("idle_flush_rd_en", 32'(rf_rd_en), 32'h0);
      @(negedge clk);
      check("idle_flush_rd_en2", 32'(rf_rd_en), 32'h0);
      @(posedge clk); #1;

      // Reset while in RS discards the instruction.
      send(32'hE1A00312, mk(32'h5, 32'h1, 2'b00, 32'd4, 1'b0, 5), 12'h320, 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rs_rst_out_valid", 32'(out_valid), 32'h0);
      check("rs_rst_in_ready", 32'(in_ready), 32'h0);
      check("rs_rst_rd_en", 32'(rf_rd_en), 32'h0);
      check("rs_rst_rd_addr", 32'(rf_rd_addr), 32'h0);
      check("rs_rst_op_a", op_a, 32'h0);
      check("rs_rst_shift_in", shift_in, 32'h0);
      check("rs_rst_shift_amt", shift_amt, 32'h0);
      rst = 1'b0;
      void'(exp_q.pop_front());
      rd_q.delete();
      @(posedge clk); #1;
      run(32'hE0870556, mk(32'h1234_5678, 32'h8000_0001, 2'b10, 32'd33, 1'b0, 5), 12'h567, 3);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      check("reads_consumed", 32'(rd_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
